ctrl_to_axilite: RTL

- Master-side bridge that issues single AXI4-Lite read/write transactions on behalf of a simple request/response control port.
- Counterpart of the AXI-Lite-slave-to-ctrl bridge. Lets emulator-side logic (e.g. a host agent or self-test sequencer) drive a remote 12-bit AXI-Lite register space.
- Exactly one transaction is outstanding at a time. A request is accepted only in IDLE.

---
 rtl/ctrl_to_axilite.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ctrl_to_axilite.sv
// ctrl_to_axilite: single-outstanding AXI4-Lite master driven by a req/resp control port
//   clk, rst_n (async active-low)
//   req_*  : request in (valid/ready, write, 10-bit word addr, wdata, wstrb)
//   resp_* : response out (valid/ready, rdata, err)
//   m_axilite_* : AXI4-Lite master channels AW, W, B, AR, R
//   Define AXILITE_MASTER_TIMEOUT_EN to abort any handshake wait after TIMEOUT_CYCLES cycles
//   (resp_err=1, resp_rdata=32'hDEAD_BEEF).
module ctrl_to_axilite #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        m_axilite_awvalid,
  input  logic        m_axilite_awready,
  output logic [11:0] m_axilite_awaddr,
  output logic [2:0]  m_axilite_awprot,
  output logic        m_axilite_wvalid,
  input  logic        m_axilite_wready,
  output logic [31:0] m_axilite_wdata,
  output logic [3:0]  m_axilite_wstrb,
  input  logic        m_axilite_bvalid,
  output logic        m_axilite_bready,
  input  logic [1:0]  m_axilite_bresp,
  output logic        m_axilite_arvalid,
  input  logic        m_axilite_arready,
  output logic [11:0] m_axilite_araddr,
  output logic [2:0]  m_axilite_arprot,
  input  logic        m_axilite_rvalid,
  output logic        m_axilite_rready,
  input  logic [31:0] m_axilite_rdata,
  input  logic [1:0]  m_axilite_rresp
);
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RESP} state_t;
  state_t state_q, state_d;
  logic aw_done, w_done, aw_fin, w_fin, tmo_hit;
  logic [9:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end
  // Handshake signals are decoded from state so an async reset drops them at once.
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign m_axilite_awvalid = state_q == WR && !aw_done;
  assign m_axilite_wvalid = state_q == WR && !w_done;
  assign m_axilite_bready = state_q == WR_B;
  assign m_axilite_arvalid = state_q == RD_AR;
  assign m_axilite_rready = state_q == RD_R;
  assign m_axilite_awaddr = {addr_q, 2'b00};
  assign m_axilite_araddr = {addr_q, 2'b00};
  assign m_axilite_awprot = 3'b000;
  assign m_axilite_arprot = 3'b000;
  assign m_axilite_wdata = wdata_q;
  assign m_axilite_wstrb = wstrb_q;
  assign aw_fin = aw_done || (m_axilite_awvalid && m_axilite_awready);
  assign w_fin = w_done || (m_axilite_wvalid && m_axilite_wready);
`ifdef AXILITE_MASTER_TIMEOUT_EN
  logic [31:0] cnt;
  logic wait_st;
  assign wait_st = state_q inside {WR, WR_B, RD_AR, RD_R};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= state_d != state_q ? '0 : wait_st ? cnt + 32'd1 : cnt;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_write ? WR : RD_AR;
      WR:      if (aw_fin && w_fin) state_d = WR_B;
      WR_B:    if (m_axilite_bvalid) state_d = RESP;
      RD_AR:   if (m_axilite_arready) state_d = RD_R;
      RD_R:    if (m_axilite_rvalid) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AXILITE_MASTER_TIMEOUT_EN
    // A completing handshake in the limit cycle already moved state_d, so it wins.
    if (wait_st && state_d == state_q && cnt == 32'(TIMEOUT_CYCLES - 1)) begin
      state_d = RESP;
      tmo_hit = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end else if (state_q == WR) begin
        aw_done <= aw_fin;
        w_done <= w_fin;
      end
      if (tmo_hit) begin
        resp_err <= 1'b1;
        resp_rdata <= 32'hDEAD_BEEF;
      end else if (state_q == WR_B && m_axilite_bvalid) begin
        resp_err <= m_axilite_bresp != 2'b00;
        resp_rdata <= '0;
      end else if (state_q == RD_R && m_axilite_rvalid) begin
        resp_err <= m_axilite_rresp != 2'b00;
        resp_rdata <= m_axilite_rdata;
      end
    end
endmodule
